// File: rtl/multi_cycle_controller_if.sv
// rtl/multi_cycle_controller_if.sv - control/status bundle between the multi-cycle FSM and its datapath
interface multi_cycle_controller_if;
  logic [6:0] opcode;
  logic       bcond;
  logic       halt_cond;
  logic       mem_ready;
  logic       pc_write;
  logic       i_or_d;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       mdr_write;
  logic       alu_out_write;
  logic       reg_write;
  logic       mem_to_reg;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [1:0] pc_source;
  logic       halted;
  logic       mem_err;
  logic       illegal;

  modport master (
    input  opcode, bcond, halt_cond, mem_ready,
    output pc_write, i_or_d, mem_read, mem_write, ir_write, mdr_write,
           alu_out_write, reg_write, mem_to_reg, alu_src_a, alu_src_b,
           alu_op, pc_source, halted, mem_err, illegal
  );

  modport slave (
    output opcode, bcond, halt_cond, mem_ready,
    input  pc_write, i_or_d, mem_read, mem_write, ir_write, mdr_write,
           alu_out_write, reg_write, mem_to_reg, alu_src_a, alu_src_b,
           alu_op, pc_source, halted, mem_err, illegal
  );
endinterface

// File: rtl/multi_cycle_controller.sv
// rtl/multi_cycle_controller.sv - FSM sequencing a shared-ALU multi-cycle RV32I datapath
module multi_cycle_controller #(
  parameter int MEM_TIMEOUT = 255
) (
  input logic                     clk,
  input logic                     reset,
  multi_cycle_controller_if.master ctl
);
  localparam int CW = $clog2(MEM_TIMEOUT + 1);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_ECALL = 7'b1110011;

  typedef enum logic [2:0] {
    S_IF, S_ID, S_EX, S_MEM, S_WB, S_BR, S_HALT
  } state_t;

  state_t        state;
  logic [CW-1:0] wait_cnt;
  logic          bcond_q;
  logic          halted_q;
  logic          mem_err_q;

  logic is_r, is_i, is_ld, is_st, is_br, is_jal, is_jalr, is_ecall, is_legal;
  logic mem_wait, timeout;

  assign is_r     = (ctl.opcode == OP_R);
  assign is_i     = (ctl.opcode == OP_I);
  assign is_ld    = (ctl.opcode == OP_LOAD);
  assign is_st    = (ctl.opcode == OP_STORE);
  assign is_br    = (ctl.opcode == OP_BR);
  assign is_jal   = (ctl.opcode == OP_JAL);
  assign is_jalr  = (ctl.opcode == OP_JALR);
  assign is_ecall = (ctl.opcode == OP_ECALL);
  assign is_legal = is_r | is_i | is_ld | is_st | is_br | is_jal | is_jalr | is_ecall;

  // Watchdog covers every state that stalls on memory; ready on the expiry cycle wins.
  assign mem_wait = (state == S_IF) || (state == S_MEM);
  assign timeout  = mem_wait && !ctl.mem_ready && (wait_cnt == CW'(MEM_TIMEOUT));

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IF;
      wait_cnt  <= '0;
      bcond_q   <= 1'b0;
      halted_q  <= 1'b0;
      mem_err_q <= 1'b0;
    end else begin
      if (mem_wait && !ctl.mem_ready && !timeout)
        wait_cnt <= wait_cnt + CW'(1);
      else
        wait_cnt <= '0;

      if (timeout) begin
        mem_err_q <= 1'b1;
        halted_q  <= 1'b1;
        state     <= S_HALT;
      end else begin
        case (state)
          S_IF: if (ctl.mem_ready) state <= S_ID;
          S_ID: begin
            if (is_ecall && ctl.halt_cond) begin
              halted_q <= 1'b1;
              state    <= S_HALT;
            end else begin
              state <= S_EX;
            end
          end
          S_EX: begin
            if (is_r || is_i)        state <= S_WB;
            else if (is_ld || is_st) state <= S_MEM;
            else if (is_br) begin
              bcond_q <= ctl.bcond;
              state   <= S_BR;
            end else                 state <= S_IF;
          end
          S_MEM:   if (ctl.mem_ready) state <= is_ld ? S_WB : S_IF;
          S_WB:    state <= S_IF;
          S_BR:    state <= S_IF;
          S_HALT:  state <= S_HALT;
          default: state <= S_IF;
        endcase
      end
    end
  end

  always_comb begin
    ctl.pc_write      = 1'b0;
    ctl.i_or_d        = 1'b0;
    ctl.mem_read      = 1'b0;
    ctl.mem_write     = 1'b0;
    ctl.ir_write      = 1'b0;
    ctl.mdr_write     = 1'b0;
    ctl.alu_out_write = 1'b0;
    ctl.reg_write     = 1'b0;
    ctl.mem_to_reg    = 1'b0;
    ctl.alu_src_a     = 1'b0;
    ctl.alu_src_b     = 2'b00;
    ctl.alu_op        = 2'b00;
    ctl.pc_source     = 2'b00;
    ctl.illegal       = 1'b0;
    ctl.halted        = halted_q;
    ctl.mem_err       = mem_err_q;
    case (state)
      S_IF: begin
        ctl.mem_read = 1'b1;
        ctl.ir_write = ctl.mem_ready;
      end
      S_ID: begin
        ctl.alu_src_b     = 2'b01;
        ctl.alu_out_write = 1'b1;
        ctl.illegal       = !is_legal;
      end
      S_EX: begin
        if (is_r || is_i) begin
          ctl.alu_src_a     = 1'b1;
          ctl.alu_src_b     = is_i ? 2'b10 : 2'b00;
          ctl.alu_op        = 2'b10;
          ctl.alu_out_write = 1'b1;
        end else if (is_ld || is_st) begin
          ctl.alu_src_a     = 1'b1;
          ctl.alu_src_b     = 2'b10;
          ctl.alu_out_write = 1'b1;
        end else if (is_br) begin
          ctl.alu_src_a = 1'b1;
          ctl.alu_op    = 2'b01;
        end else if (is_jal || is_jalr) begin
          // rd takes ALUOut (PC+4 from ID) while the ALU computes the target
          ctl.reg_write = 1'b1;
          ctl.alu_src_a = is_jalr;
          ctl.alu_src_b = 2'b10;
          ctl.pc_source = is_jalr ? 2'b10 : 2'b00;
          ctl.pc_write  = 1'b1;
        end else begin
          ctl.alu_src_b = 2'b01;
          ctl.pc_write  = 1'b1;
        end
      end
      S_MEM: begin
        ctl.i_or_d = 1'b1;
        if (is_ld) begin
          ctl.mem_read  = 1'b1;
          ctl.mdr_write = ctl.mem_ready;
        end else begin
          ctl.mem_write = 1'b1;
          ctl.alu_src_b = ctl.mem_ready ? 2'b01 : 2'b00;
          ctl.pc_write  = ctl.mem_ready;
        end
      end
      S_WB: begin
        ctl.reg_write  = 1'b1;
        ctl.mem_to_reg = is_ld;
        ctl.alu_src_b  = 2'b01;
        ctl.pc_write   = 1'b1;
      end
      S_BR: begin
        ctl.alu_src_b = 2'b10;
        ctl.pc_write  = 1'b1;
        ctl.pc_source = bcond_q ? 2'b00 : 2'b01;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_multi_cycle_controller.sv
// tb/tb_multi_cycle_controller.sv - scoreboard bench for multi_cycle_controller
module tb_multi_cycle_controller;
  localparam logic [19:0] PCW  = 20'h80000, IOD  = 20'h40000, MRD  = 20'h20000;
  localparam logic [19:0] MWR  = 20'h10000, IRW  = 20'h08000, MDRW = 20'h04000;
  localparam logic [19:0] AOW  = 20'h02000, RW   = 20'h01000, M2R  = 20'h00800;
  localparam logic [19:0] SA   = 20'h00400, SBI  = 20'h00200, SB4  = 20'h00100;
  localparam logic [19:0] OPF  = 20'h00080, OPBR = 20'h00040, PSJR = 20'h00020;
  localparam logic [19:0] PSAO = 20'h00010, HLT  = 20'h00008, MERR = 20'h00004;
  localparam logic [19:0] ILL  = 20'h00002;

  localparam logic [6:0] OR_ = 7'b0110011, OI = 7'b0010011, OLD = 7'b0000011;
  localparam logic [6:0] OST = 7'b0100011, OBR = 7'b1100011, OJAL = 7'b1101111;
  localparam logic [6:0] OJR = 7'b1100111, OEC = 7'b1110011, OBAD = 7'b1111111;

  localparam logic [19:0] E_IF = MRD | IRW;
  localparam logic [19:0] E_ID = SB4 | AOW;

  logic clk = 1'b0;
  logic reset;
  logic done = 1'b0;
  int checks = 0;
  int failures = 0;
  logic [19:0] exp_q[$];
  string name_q[$];
  logic [19:0] act;

  multi_cycle_controller_if bus();

  multi_cycle_controller #(.MEM_TIMEOUT(4)) dut (
    .clk(clk),
    .reset(reset),
    .ctl(bus)
  );

  always #5 clk = ~clk;

  assign act = {bus.pc_write, bus.i_or_d, bus.mem_read, bus.mem_write, bus.ir_write,
                bus.mdr_write, bus.alu_out_write, bus.reg_write, bus.mem_to_reg,
                bus.alu_src_a, bus.alu_src_b, bus.alu_op, bus.pc_source,
                bus.halted, bus.mem_err, bus.illegal, 1'b0};

  task automatic step(input logic [6:0] op, input logic rdy, input logic bc,
                      input logic hc, input logic [19:0] e, input string nm);
    bus.opcode    = op;
    bus.mem_ready = rdy;
    bus.bcond     = bc;
    bus.halt_cond = hc;
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  task automatic rst_cycle();
    reset         = 1'b1;
    bus.mem_ready = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [19:0] e;
      string nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      checks++;
      if (act !== e) begin
        failures++;
        $display("FAIL %s: got %h expected %h", nm, act, e);
      end
    end else if (done) begin
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    bus.opcode = OR_;
    bus.mem_ready = 1'b1;
    bus.bcond = 1'b0;
    bus.halt_cond = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    step(OR_, 1, 0, 0, E_IF, "r_if");
    step(OR_, 1, 0, 0, E_ID, "r_id");
    step(OR_, 1, 0, 0, SA | OPF | AOW, "r_ex");
    step(OR_, 1, 0, 0, RW | SB4 | PCW, "r_wb");

    step(OI, 1, 0, 0, E_IF, "i_if");
    step(OI, 1, 0, 0, E_ID, "i_id");
    step(OI, 1, 0, 0, SA | SBI | OPF | AOW, "i_ex");
    step(OI, 1, 0, 0, RW | SB4 | PCW, "i_wb");

    step(OLD, 1, 0, 0, E_IF, "ld_if");
    step(OLD, 1, 0, 0, E_ID, "ld_id");
    step(OLD, 1, 0, 0, SA | SBI | AOW, "ld_ex");
    for (int k = 0; k < 3; k++) step(OLD, 0, 0, 0, IOD | MRD, "ld_mem_wait");
    step(OLD, 1, 0, 0, IOD | MRD | MDRW, "ld_mem_ready");
    step(OLD, 1, 0, 0, RW | M2R | SB4 | PCW, "ld_wb");

    step(OST, 1, 0, 0, E_IF, "st_if");
    step(OST, 1, 0, 0, E_ID, "st_id");
    step(OST, 1, 0, 0, SA | SBI | AOW, "st_ex");
    step(OST, 1, 0, 0, IOD | MWR | SB4 | PCW, "st_mem");

    step(OBR, 1, 0, 0, E_IF, "bt_if");
    step(OBR, 1, 0, 0, E_ID, "bt_id");
    step(OBR, 1, 1, 0, SA | OPBR, "bt_ex");
    step(OBR, 1, 0, 0, SBI | PCW, "bt_br");
    step(OBR, 1, 0, 0, E_IF, "bn_if");
    step(OBR, 1, 0, 0, E_ID, "bn_id");
    step(OBR, 1, 0, 0, SA | OPBR, "bn_ex");
    step(OBR, 1, 1, 0, SBI | PCW | PSAO, "bn_br");

    step(OJAL, 1, 0, 0, E_IF, "jal_if");
    step(OJAL, 1, 0, 0, E_ID, "jal_id");
    step(OJAL, 1, 0, 0, RW | SBI | PCW, "jal_ex");
    step(OJR, 1, 0, 0, E_IF, "jalr_if");
    step(OJR, 1, 0, 0, E_ID, "jalr_id");
    step(OJR, 1, 0, 0, RW | SA | SBI | PSJR | PCW, "jalr_ex");

    step(OEC, 1, 0, 0, E_IF, "ec_if");
    step(OEC, 1, 0, 0, E_ID, "ec_id");
    step(OEC, 1, 0, 0, SB4 | PCW, "ec_ex");

    step(OBAD, 1, 0, 0, E_IF, "bad_if");
    step(OBAD, 1, 0, 0, E_ID | ILL, "bad_id");
    step(OBAD, 1, 0, 0, SB4 | PCW, "bad_ex");

    for (int k = 0; k < 4; k++) step(OR_, 0, 0, 0, MRD, "wd_ok_wait");
    step(OR_, 1, 0, 0, E_IF, "wd_ok_ready");
    step(OR_, 1, 0, 0, E_ID, "wd_ok_id");
    step(OR_, 1, 0, 0, SA | OPF | AOW, "wd_ok_ex");
    step(OR_, 1, 0, 0, RW | SB4 | PCW, "wd_ok_wb");

    for (int k = 0; k < 5; k++) step(OR_, 0, 0, 0, MRD, "wd_flt_wait");
    for (int k = 0; k < 3; k++) step(OR_, 1, 0, 0, HLT | MERR, "wd_flt_halt");
    rst_cycle();

    step(OST, 1, 0, 0, E_IF, "rs_if");
    step(OST, 1, 0, 0, E_ID, "rs_id");
    step(OST, 1, 0, 0, SA | SBI | AOW, "rs_ex");
    step(OST, 0, 0, 0, IOD | MWR, "rs_mem_wait");
    rst_cycle();
    for (int k = 0; k < 4; k++) step(OST, 0, 0, 0, MRD, "rs_after_if_wait");
    step(OST, 1, 0, 0, E_IF, "rs_after_if_ready");

    step(OEC, 1, 0, 1, E_ID, "hlt_id");
    for (int k = 0; k < 22; k++) step(OEC, k[0], k[1], 1, HLT, "hlt_hold");
    rst_cycle();
    step(OR_, 1, 0, 0, E_IF, "hlt_reset_if");
    step(OR_, 1, 0, 0, E_ID, "hlt_reset_id");

    checks++;
    if (bus.halted !== 1'b0) begin
      failures++;
      $display("FAIL post_reset_halted: got %b", bus.halted);
    end
    checks++;
    if (bus.mem_err !== 1'b0) begin
      failures++;
      $display("FAIL post_reset_mem_err: got %b", bus.mem_err);
    end
    checks++;
    if (bus.pc_write !== 1'b0) begin
      failures++;
      $display("FAIL post_reset_ex_pc_write: got %b", bus.pc_write);
    end
    checks++;
    if (bus.alu_src_a !== 1'b1) begin
      failures++;
      $display("FAIL post_reset_ex_alu_src_a: got %b", bus.alu_src_a);
    end
    checks++;
    if (bus.alu_op !== 2'b10) begin
      failures++;
      $display("FAIL post_reset_ex_alu_op: got %b", bus.alu_op);
    end

    done = 1'b1;
  end
endmodule
